// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between requesters and the 8-way round-robin arbiter.
// The arbiter takes the slave side; the requester side drives req.
interface rr_arbiter_8_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  modport master (output req, input gnt, input gnt_idx, input gnt_valid);
  modport slave  (input req, output gnt, output gnt_idx, output gnt_valid);
endinterface

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with registered one-hot and encoded grant outputs.
// A hold-limit counter forces rotation away from an owner while others are waiting.
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 4,
  parameter int HC_W     = 8
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter_8_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [HC_W-1:0] MAX_HOLD_C = HC_W'(MAX_HOLD);

  state_t          state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [HC_W-1:0] hold_q, hold_d;
  logic [7:0]      gnt_q, gnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            vld_q, vld_d;

  logic [7:0]      others;
  logic [3:0]      pick_req, pick_oth;
  logic            grant_en;
  logic [2:0]      grant_w;

  // Returns {found, index}: first set bit of m at or above p, wrapping 7 -> 0.
  function automatic logic [3:0] pick(input logic [2:0] p, input logic [7:0] m);
    logic [3:0] r;
    logic [2:0] j;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      j = p + 3'(i);
      if (m[j]) r = {1'b1, j};
    end
    return r;
  endfunction

  assign others   = bus.req & ~(8'(1) << idx_q);
  assign pick_req = pick(ptr_q, bus.req);
  assign pick_oth = pick(ptr_q, others);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    gnt_d    = gnt_q;
    idx_d    = idx_q;
    vld_d    = vld_q;
    grant_en = 1'b0;
    grant_w  = 3'd0;

    case (state_q)
      IDLE: begin
        if (pick_req[3]) begin
          grant_en = 1'b1;
          grant_w  = pick_req[2:0];
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (!bus.req[idx_q]) begin
          if (pick_oth[3]) begin
            grant_en = 1'b1;
            grant_w  = pick_oth[2:0];
          end else begin
            state_d = IDLE;
            hold_d  = '0;
            gnt_d   = '0;
            idx_d   = '0;
            vld_d   = 1'b0;
          end
        end else if (pick_oth[3] && hold_q == MAX_HOLD_C) begin
          grant_en = 1'b1;
          grant_w  = pick_oth[2:0];
        end else if (hold_q < MAX_HOLD_C) begin
          // Also covers the sole holder, whose count saturates at the limit.
          hold_d = hold_q + HC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_en) begin
      ptr_d  = grant_w + 3'd1;
      hold_d = HC_W'(1);
      gnt_d  = 8'(1) << grant_w;
      idx_d  = grant_w;
      vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = vld_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: two instances (hold limits 4 and 1) driven in lockstep,
// a queue-based scoreboard fed by a reference model, plus directed expectations.
module tb_rr_arbiter_8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_arbiter_8_if bus0 ();
  rr_arbiter_8_if bus1 ();

  rr_arbiter_8 #(.MAX_HOLD(4), .HC_W(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  rr_arbiter_8 #(.MAX_HOLD(1), .HC_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_chk  = 0;
  int n_fail = 0;

  logic [11:0] exp_q0[$];
  logic [11:0] exp_q1[$];

  int m_owner[2];
  int m_ptr[2];
  int m_hold[2];
  int lim[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mpick(input int p, input logic [7:0] m);
    for (int k = 0; k < 8; k++)
      if (m[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  task automatic mgrant(input int d, input int w);
    m_owner[d] = w;
    m_ptr[d]   = (w + 1) % 8;
    m_hold[d]  = 1;
  endtask

  task automatic model_step(input int d, input logic [7:0] r, input logic rs);
    int w;
    logic [7:0] oth;
    if (rs) begin
      m_owner[d] = -1;
      m_ptr[d]   = 0;
      m_hold[d]  = 0;
    end else if (m_owner[d] < 0) begin
      w = mpick(m_ptr[d], r);
      if (w >= 0) mgrant(d, w);
    end else begin
      oth = r;
      oth[m_owner[d]] = 1'b0;
      if (!r[m_owner[d]]) begin
        w = mpick(m_ptr[d], oth);
        if (w >= 0) mgrant(d, w);
        else begin
          m_owner[d] = -1;
          m_hold[d]  = 0;
        end
      end else if (oth != 8'h00 && m_hold[d] >= lim[d]) begin
        mgrant(d, mpick(m_ptr[d], oth));
      end else if (m_hold[d] < lim[d]) begin
        m_hold[d]++;
      end
    end
  endtask

  function automatic logic [11:0] mexp(input int d);
    logic [7:0] g;
    if (m_owner[d] < 0) return 12'h000;
    g = 8'h00;
    g[m_owner[d]] = 1'b1;
    return {g, 3'(m_owner[d]), 1'b1};
  endfunction

  task automatic check_out(input string name, input logic [11:0] e,
                           input logic [7:0] g, input logic [2:0] ix, input logic v);
    int enc;
    enc = 0;
    for (int k = 0; k < 8; k++) if (g[k]) enc = k;
    check_eq({name, ".gnt"}, 32'(g), 32'(e[11:4]));
    check_eq({name, ".idx"}, 32'(ix), 32'(e[3:1]));
    check_eq({name, ".vld"}, 32'(v), 32'(e[0]));
    check_eq({name, ".onehot0"}, 32'($onehot0(g)), 32'd1);
    check_eq({name, ".encode"}, 32'(ix), 32'(enc));
    check_eq({name, ".or"}, 32'(v), 32'(|g));
  endtask

  // One clock: drive on the falling edge, predict, then compare 1 time unit after the rising edge.
  task automatic cycle(input logic [7:0] r, input logic rs);
    @(negedge clk);
    rst      = rs;
    bus0.req = r;
    bus1.req = r;
    model_step(0, r, rs);
    exp_q0.push_back(mexp(0));
    model_step(1, r, rs);
    exp_q1.push_back(mexp(1));
    @(posedge clk);
    #1;
    check_out("d0", exp_q0.pop_front(), bus0.gnt, bus0.gnt_idx, bus0.gnt_valid);
    check_out("d1", exp_q1.pop_front(), bus1.gnt, bus1.gnt_idx, bus1.gnt_valid);
  endtask

  task automatic dchk(input string tag, input logic [7:0] g, input logic [2:0] ix);
    check_eq({tag, ".gnt"}, 32'(bus0.gnt), 32'(g));
    check_eq({tag, ".idx"}, 32'(bus0.gnt_idx), 32'(ix));
  endtask

  initial begin
    logic [7:0] r;
    logic       rs;
    lim      = '{4, 1};
    m_owner  = '{-1, -1};
    m_ptr    = '{0, 0};
    m_hold   = '{0, 0};
    rst      = 1'b1;
    bus0.req = 8'h00;
    bus1.req = 8'h00;

    cycle(8'h00, 1'b1);
    dchk("reset", 8'h00, 3'd0);
    check_eq("reset.vld", 32'(bus0.gnt_valid), 32'd0);

    for (int k = 1; k <= 9; k++) begin
      cycle(8'h14, 1'b0);
      if (k <= 4 || k == 9) dchk($sformatf("alt%0d", k), 8'h04, 3'd2);
      else                  dchk($sformatf("alt%0d", k), 8'h10, 3'd4);
    end

    cycle(8'h00, 1'b1);
    cycle(8'h80, 1'b0);
    dchk("wrap.own7", 8'h80, 3'd7);
    cycle(8'h01, 1'b0);
    dchk("wrap.to0", 8'h01, 3'd0);
    check_eq("wrap.vld", 32'(bus0.gnt_valid), 32'd1);

    cycle(8'h00, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      cycle(8'h20, 1'b0);
      dchk($sformatf("sole%0d", k), 8'h20, 3'd5);
    end
    cycle(8'h00, 1'b0);
    dchk("sole.rel", 8'h00, 3'd0);
    check_eq("sole.rel.vld", 32'(bus0.gnt_valid), 32'd0);

    cycle(8'h00, 1'b1);
    for (int k = 1; k <= 32; k++) begin
      cycle(8'hFF, 1'b0);
      dchk($sformatf("fair%0d", k), 8'(1) << ((k - 1) / 4), 3'((k - 1) / 4));
      check_eq($sformatf("fair1_%0d.idx", k), 32'(bus1.gnt_idx), 32'((k - 1) % 8));
    end

    cycle(8'h00, 1'b1);
    repeat (13) cycle(8'hFF, 1'b0);
    dchk("mid.own3", 8'h08, 3'd3);
    cycle(8'hFF, 1'b1);
    dchk("mid.rst", 8'h00, 3'd0);
    check_eq("mid.rst.vld", 32'(bus0.gnt_valid), 32'd0);
    cycle(8'hFF, 1'b0);
    dchk("mid.after", 8'h01, 3'd0);

    cycle(8'h00, 1'b1);
    cycle(8'h04, 1'b0);
    dchk("ptr.own2", 8'h04, 3'd2);
    cycle(8'h45, 1'b0);
    dchk("ptr.hold2", 8'h04, 3'd2);
    cycle(8'h41, 1'b0);
    dchk("ptr.next6", 8'h40, 3'd6);

    for (int k = 0; k < 400; k++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
      rs = ($urandom_range(0, 49) == 0);
      cycle(r, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
